dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Data-bus slave directly downstream of the data-memory interface stage.
//  It accepts one word-addressed, byte-enabled request at a time (bus_addr/bus_data_in/bus_byteen/bus_we/bus_re).
//  It services the request from an internal byte-lane RAM after WAIT_CYCLES wait states, holding the core with bus_stall.
//  It returns the full aligned word on bus_data_out; the upstream stage does lane shifting and sign extension.
// PARAMETERS
//  WIDTH        32           data/address width (only 32 supported)
//  DEPTH_WORDS  1024         RAM size in 32-bit words (power of two)
//  BASE_ADDR    32'h0000_0000 byte address of word 0 (DEPTH_WORDS*4 aligned)
//  WAIT_CYCLES  1            wait states before access commits (>=1, <=255)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  bus_addr      in   WIDTH  byte address; held stable by core while bus_stall=1
//  bus_data_in   in   WIDTH  write data, already shifted into byte lanes
//  bus_byteen    in   4      byte-lane enables, bit i = bits [8i+7:8i]
//  bus_we        in   1      write request
//  bus_re        in   1      read request
//  bus_data_out  out  WIDTH  read word, valid in RESP cycle, held until next read completes
//  bus_stall     out  1      1 = request accepted and not yet complete; core must freeze
//  bus_err       out  1      1 in RESP cycle if request was rejected
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE, cnt=0, rdata=0, err=0.
//   - bus_stall=0, bus_data_out=0, bus_err=0 while rst=1.
//   - RAM contents are not cleared.
//   - A pending write that has not committed is discarded.
//  State machine (IDLE, WAIT, RESP):
//   - IDLE, req=(bus_re|bus_we):
//     - bus_stall=1 combinationally.
//     - Next state WAIT; cnt<=WAIT_CYCLES-1.
//     - Request fields are latched.
//   - IDLE, no req: bus_stall=0.
//   - WAIT: bus_stall=1.
//     - cnt!=0: cnt<=cnt-1.
//     - cnt==0: commit access at this edge, then go to RESP.
//   - RESP: bus_stall=0; bus_err=err.
//     - Next state IDLE unconditionally.
//     - The still-present request in RESP is the completed one and must not restart.
//  Timing:
//   - Request first seen in cycle 0.
//   - bus_stall=1 in cycles 0..WAIT_CYCLES.
//   - RESP is cycle WAIT_CYCLES+1.
//   - Back-to-back requests: the next IDLE cycle accepts the new request (2-cycle bubble minimum).
//  Commit:
//   - Read: rdata<=mem[idx] (full word; byteen ignored).
//   - Write: mem[idx] lane i <= bus_data_in lane i for each set bus_byteen[i].
//   - idx = (bus_addr-BASE_ADDR)>>2.
//  Error (err=1, no RAM write, rdata unchanged):
//   - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
//   - bus_we and bus_re both 1.
//   - bus_byteen not in {0001,0010,0100,1000,0011,1100,1111}.
//   - bus_byteen=0011 with addr[1:0] not 00, or 1100 with addr[1:0] not 10.
//   - bus_byteen=1111 with addr[1:0]!=00.
//   - bus_byteen=0000 on a write.
//   - Errors still take the full WAIT_CYCLES+1 stall.
//  Checks and latching:
//   - Error checks use the request latched in cycle 0.
//   - Inputs changing while bus_stall=1 are ignored.
//  Reset during WAIT: returns to IDLE, no commit, bus_stall drops immediately.
// TESTING
//  - SW 0x11223344 @0x10, byteen 1111, WAIT_CYCLES=1 -> stall 2 cycles; then LW @0x10 -> bus_data_out=0x11223344 in RESP.
//  - SB data 0x0000AC00 @0x25, byteen 0010 over word 0xFFFFFFFF -> LW @0x24 returns 0xFFFFAC FF, i.e. 0xFFFFACFF.
//  - LW @0x12 with byteen 1111 -> bus_err=1 in RESP, RAM unchanged, rdata holds previous 0xFFFFACFF.
//  - Address BASE_ADDR+4*DEPTH_WORDS read -> bus_err=1; bus_re & bus_we both set -> bus_err=1, no write.
//  - WAIT_CYCLES=3, SW 0xDEADBEEF, rst pulsed in 2nd WAIT cycle -> stall 0 at once, later LW returns old word.
//  - Back-to-back SW @0x0 then LW @0x0 -> second request accepted in IDLE after RESP, returns new data, no double write.

Source files
------------

// File: rtl/dmem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_if
// Description : Data-memory bus between the core's memory stage (master) and
//               the data-bus slave (slave). Carries one byte-enabled,
//               word-addressed request at a time plus the stall/err/data
//               response.
//   bus_addr     master->slave  byte address, held while bus_stall=1
//   bus_data_in  master->slave  write data already placed in byte lanes
//   bus_byteen   master->slave  byte-lane enables
//   bus_we       master->slave  write request
//   bus_re       master->slave  read request
//   bus_data_out slave->master  aligned read word
//   bus_stall    slave->master  request accepted and not yet complete
//   bus_err      slave->master  request rejected (valid in response cycle)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bus_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] bus_addr;
    logic [WIDTH-1:0] bus_data_in;
    logic [3:0]       bus_byteen;
    logic             bus_we;
    logic             bus_re;
    logic [WIDTH-1:0] bus_data_out;
    logic             bus_stall;
    logic             bus_err;

    modport master (
        output bus_addr, bus_data_in, bus_byteen, bus_we, bus_re,
        input  bus_data_out, bus_stall, bus_err
    );

    modport slave (
        input  bus_addr, bus_data_in, bus_byteen, bus_we, bus_re,
        output bus_data_out, bus_stall, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-bus slave with an internal byte-lane RAM. Accepts one
//               request, stalls the core for WAIT_CYCLES wait states, commits
//               the access and returns the full aligned word (or an error) in
//               a single response cycle.
//   clk   in  clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of dmem_bus_if (request in, stall/err/data out)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dmem_bus_if.slave  bus
);
    localparam int               c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WIDTH-1:0] c_span  = WIDTH'(4 * DEPTH_WORDS);
    localparam logic [7:0]       c_cnt_init = 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cnt;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_err;
    logic [c_idx_w-1:0]   r_idx;
    logic [WIDTH-1:0]     r_wdata;
    logic [3:0]           r_be;
    logic                 r_we;

    logic                 w_req;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_commit;
    logic [WIDTH-1:0]     w_off;
    logic                 w_in_range;
    logic                 w_be_ok;
    logic                 w_req_err;
    logic [WIDTH-1:0]     w_rd_word;

    // ------------------------------------------------------------------
    // Request checking on the live bus; only used at the accept edge.
    // ------------------------------------------------------------------
    assign w_req      = bus.bus_re | bus.bus_we;
    assign w_off      = bus.bus_addr - BASE_ADDR;
    // Subtracting first keeps the upper bound correct even if the RAM
    // window ends at the very top of the address space.
    assign w_in_range = (bus.bus_addr >= BASE_ADDR) && (w_off < c_span);

    // A zero byte-enable is harmless on a read (the whole word comes back
    // regardless), so only a zero-enable write is rejected.
    always_comb begin
        w_be_ok = 1'b0;
        case (bus.bus_byteen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
            4'b0011: w_be_ok = (bus.bus_addr[1:0] == 2'b00);
            4'b1100: w_be_ok = (bus.bus_addr[1:0] == 2'b10);
            4'b1111: w_be_ok = (bus.bus_addr[1:0] == 2'b00);
            4'b0000: w_be_ok = ~bus.bus_we;
            default: w_be_ok = 1'b0;
        endcase
    end

    assign w_req_err = ~w_in_range | (bus.bus_we & bus.bus_re) | ~w_be_ok;

    // ------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall     = 1'b1;
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            // The request is still on the bus here but it is the one just
            // completed; always return to IDLE without re-accepting.
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= 4'b0000;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= c_cnt_init;
                r_err   <= w_req_err;
                // BASE_ADDR is aligned to the RAM size, so the word index is
                // simply the address bits just above the byte offset.
                r_idx   <= w_off[c_idx_w+1:2];
                r_wdata <= bus.bus_data_in;
                r_be    <= bus.bus_byteen;
                r_we    <= bus.bus_we;
            end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_commit && !r_err && !r_we) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane RAM, one array per lane; contents survive reset.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (w_commit && !r_err && r_we && r_be[g]) begin
                r_mem[r_idx] <= r_wdata[8*g +: 8];
            end
        end

        assign w_rd_word[8*g +: 8] = r_mem[r_idx];
    end

    // ------------------------------------------------------------------
    // Outputs. Stall is masked by rst so it drops the moment reset is
    // applied, even with a request still sitting on the bus.
    // ------------------------------------------------------------------
    assign bus.bus_stall    = w_stall & ~rst;
    assign bus.bus_err      = (r_state == S_RESP) & r_err;
    assign bus.bus_data_out = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Self-checking bench for dmem_bus_ctrl. One instance with one
//               wait state runs a table of directed requests; a second with
//               three wait states covers reset during a pending write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;
    logic clk;
    logic rst;

    int n_chk;
    int n_fail;

    dmem_bus_if #(.WIDTH(32)) bus1 ();
    dmem_bus_if #(.WIDTH(32)) bus3 ();

    dmem_bus_ctrl #(
        .WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    dmem_bus_ctrl #(
        .WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic exp_err, input logic chk_data,
                                input logic [31:0] exp_data);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.data = data; v.be = be;
        v.exp_err = exp_err; v.chk_data = chk_data; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        if (sel) begin
            bus3.bus_we = we; bus3.bus_re = re; bus3.bus_addr = addr;
            bus3.bus_data_in = data; bus3.bus_byteen = be;
        end else begin
            bus1.bus_we = we; bus1.bus_re = re; bus1.bus_addr = addr;
            bus1.bus_data_in = data; bus1.bus_byteen = be;
        end
    endtask

    task automatic sample(input bit sel, output logic st, output logic er, output logic [31:0] dq);
        if (sel) begin
            st = bus3.bus_stall; er = bus3.bus_err; dq = bus3.bus_data_out;
        end else begin
            st = bus1.bus_stall; er = bus1.bus_err; dq = bus1.bus_data_out;
        end
    endtask

    // One full request: count stalled cycles, check the response cycle, keep
    // the request on the bus across the RESP->IDLE edge, then confirm that
    // the controller is idle (no restart of the completed request).
    task automatic xact(input bit sel, input string name, input vec_t v, input int waitc);
        logic st, er;
        logic [31:0] dq;
        int n;
        n = 0;
        drive(sel, v.we, v.re, v.addr, v.data, v.be);
        #1;
        sample(sel, st, er, dq);
        while (st && n < 40) begin
            n++;
            @(posedge clk); #1;
            sample(sel, st, er, dq);
        end
        check({name, " stall_cycles"}, 32'(n), 32'(waitc + 1));
        check({name, " err"}, {31'd0, er}, {31'd0, v.exp_err});
        if (v.chk_data) check({name, " rdata"}, dq, v.exp_data);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        sample(sel, st, er, dq);
        check({name, " idle_after_resp"}, {31'd0, st}, 32'd0);
    endtask

    initial begin
        logic st, er;
        logic [31:0] dq;
        n_chk  = 0;
        n_fail = 0;

        // ---------------- reset state, with requests present ----------------
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        #3;
        check("rst stall1", {31'd0, bus1.bus_stall}, 32'd0);
        check("rst stall3", {31'd0, bus3.bus_stall}, 32'd0);
        check("rst err1", {31'd0, bus1.bus_err}, 32'd0);
        check("rst dout1", bus1.bus_data_out, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- table of directed requests, WAIT_CYCLES=1 ----------------
        vecs.push_back(mk(1,0,32'h10,  32'h11223344,4'hF,0,0,32'h0));        // 0 SW
        vecs.push_back(mk(0,1,32'h10,  32'h0,       4'hF,0,1,32'h11223344)); // 1 LW
        vecs.push_back(mk(1,0,32'h24,  32'hFFFFFFFF,4'hF,0,0,32'h0));        // 2 SW
        vecs.push_back(mk(1,0,32'h25,  32'h0000AC00,4'h2,0,0,32'h0));        // 3 SB lane1
        vecs.push_back(mk(0,1,32'h24,  32'h0,       4'hF,0,1,32'hFFFFACFF)); // 4 LW
        vecs.push_back(mk(0,1,32'h12,  32'h0,       4'hF,1,1,32'hFFFFACFF)); // 5 misaligned word
        vecs.push_back(mk(0,1,32'h1000,32'h0,       4'hF,1,1,32'hFFFFACFF)); // 6 out of range
        vecs.push_back(mk(1,1,32'h10,  32'hCAFEF00D,4'hF,1,1,32'hFFFFACFF)); // 7 we&re
        vecs.push_back(mk(0,1,32'h10,  32'h0,       4'hF,0,1,32'h11223344)); // 8 no write from 7
        vecs.push_back(mk(1,0,32'h26,  32'hBEEF0000,4'hC,0,0,32'h0));        // 9 SH upper
        vecs.push_back(mk(0,1,32'h24,  32'h0,       4'hF,0,1,32'hBEEFACFF)); // 10 LW
        vecs.push_back(mk(1,0,32'h24,  32'h12340000,4'hC,1,1,32'hBEEFACFF)); // 11 1100 @00
        vecs.push_back(mk(1,0,32'h22,  32'h00005678,4'h3,1,1,32'hBEEFACFF)); // 12 0011 @10
        vecs.push_back(mk(1,0,32'h24,  32'h12345678,4'h5,1,1,32'hBEEFACFF)); // 13 illegal be
        vecs.push_back(mk(1,0,32'h24,  32'h12345678,4'h0,1,1,32'hBEEFACFF)); // 14 zero be write
        vecs.push_back(mk(0,1,32'h24,  32'h0,       4'hF,0,1,32'hBEEFACFF)); // 15 RAM unchanged
        vecs.push_back(mk(1,0,32'h13,  32'h55000000,4'h8,0,0,32'h0));        // 16 SB lane3
        vecs.push_back(mk(0,1,32'h10,  32'h0,       4'hF,0,1,32'h55223344)); // 17 LW
        vecs.push_back(mk(1,0,32'hFFC, 32'h0BADF00D,4'hF,0,0,32'h0));        // 18 last word
        vecs.push_back(mk(0,1,32'hFFC, 32'h0,       4'hF,0,1,32'h0BADF00D)); // 19 LW last word
        vecs.push_back(mk(1,0,32'h0,   32'hA5A5A5A5,4'hF,0,0,32'h0));        // 20 SW @0
        vecs.push_back(mk(0,1,32'h0,   32'h0,       4'hF,0,1,32'hA5A5A5A5)); // 21 back-to-back LW

        foreach (vecs[i]) begin
            xact(1'b0, $sformatf("vec%0d", i), vecs[i], 1);
        end

        // ---------------- WAIT_CYCLES=3, reset during a pending write ----------------
        xact(1'b1, "w3 sw", mk(1,0,32'h8,32'h01020304,4'hF,0,0,32'h0), 3);
        xact(1'b1, "w3 lw", mk(0,1,32'h8,32'h0,4'hF,0,1,32'h01020304), 3);

        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 4'hF);   // cycle 0
        #1;
        sample(1'b1, st, er, dq);
        check("w3rst stall_c0", {31'd0, st}, 32'd1);
        @(posedge clk); #1;                                   // first WAIT cycle
        sample(1'b1, st, er, dq);
        check("w3rst stall_c1", {31'd0, st}, 32'd1);
        @(posedge clk); #1;                                   // second WAIT cycle
        rst = 1'b1;
        #1;
        sample(1'b1, st, er, dq);
        check("w3rst stall_now", {31'd0, st}, 32'd0);
        check("w3rst dout", dq, 32'h0);
        check("w3rst dout1", bus1.bus_data_out, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample(1'b1, st, er, dq);
        check("w3rst stall_after", {31'd0, st}, 32'd0);
        xact(1'b1, "w3 lw_old", mk(0,1,32'h8,32'h0,4'hF,0,1,32'h01020304), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
